activation_unit: RTL and testbench
==================================

Name: activation_unit

Overview:
- Multi-lane, pipelined activation stage for the NPU datapath, operating on signed fixed-point (default Q8.8) vectors.
- Generalises the combinational single-lane ReLU with: LANES parallel lanes, runtime-selectable activation mode, a 2-stage valid/ready pipeline with backpressure, and an optional per-beat sparsity count.
- Sits between the accumulator/output of the MAC array and the writeback buffer.

Parameters:
- WIDTH, 16, bit width of one lane (two's complement fixed point)
- FRAC, 8, fractional bits; used only to form the ReLU6 ceiling constant
- LANES, 4, number of parallel lanes per beat
- LEAK_SHIFT, 3, arithmetic right shift applied to negative inputs in leaky mode (slope 2^-LEAK_SHIFT)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_val  in  1  input beat valid
- in_rdy  out  1  unit can accept a beat this cycle
- in_mode  in  2  activation mode; sampled with the beat
- in_data  in  LANES*WIDTH  lane i occupies bits [i*WIDTH +: WIDTH]
- out_val  out  1  output beat valid
- out_rdy  in  1  downstream accepts the beat
- out_data  out  LANES*WIDTH  activated lanes, same packing as in_data
- out_zeros  out  $clog2(LANES+1)  number of zero output lanes in the beat (present only with ACTIVATION_ZCNT_EN)

Behaviour:
- Clock is clk; reset is rst, synchronous and active-high. All state updates on posedge clk.
- Handshake: a transfer occurs when val && rdy are both high in the same cycle. in_data and in_mode are sampled only on input transfer.
- Pipeline stages:
  - S1 registers {data, mode, valid}.
  - S2 registers {activated data, zero count, valid}.
  - out_* is driven directly from S2 registers. There is no combinational path from in_* to out_*.
- Stage advance rules:
  - S2 loads when S1 is valid and (S2 is empty or out_rdy is high).
  - S1 loads on input transfer.
  - in_rdy = !S1.valid || S2 will load this cycle. This gives full throughput: one beat per cycle with out_rdy held high.
- Latency: exactly 2 cycles from input transfer to out_val, with no stall. Beats are never dropped, duplicated or reordered.
- Stalls: while out_val is high and out_rdy is low, out_data, out_zeros and out_val must hold stable. After at most 2 beats are buffered, in_rdy goes low.
- Simultaneous events: when S2 drains and S1 refills in the same cycle, both happen; this is required for full throughput.
- Modes (per lane, x signed):
  - 0 PASS: y = x
  - 1 RELU: y = (x < 0) ? 0 : x
  - 2 LEAKY: y = (x < 0) ? (x >>> LEAK_SHIFT) : x. The shift is arithmetic with truncation toward -inf, so the result is never positive.
  - 3 RELU6: y = (x < 0) ? 0 : min(x, 6 << FRAC). The comparison is signed at WIDTH bits.
- Each lane is independent. All lanes in a beat use that beat's sampled mode.
- Reset:
  - out_val = 0, S1/S2 valid = 0, in_rdy = 1 in the cycle after reset deasserts.
  - out_data = 0, out_zeros = 0.
  - Reset mid-stream discards all in-flight beats. No output may appear for them after reset.
- Boundary values:
  - Mode 1 or 3 with the most negative value (0x8000) gives 0.
  - Mode 2 with 0x8000 gives 0xF000.
  - Mode 3 with 0x7FFF gives 0x0600.

Optional Feature:
- Macro: ACTIVATION_ZCNT_EN.
- With the macro defined:
  - out_zeros exists and is registered in S2 alongside out_data.
  - It equals the count of lanes whose activated output is exactly 0, including inputs that were already 0.
  - It resets to 0 and holds stable during stalls.
- Without the macro: the port and its logic are absent, and all other behaviour is identical.

Decomposition:
- Shared package npu_pkg:
  - act_mode_t enum: ACT_PASS = 0, ACT_RELU = 1, ACT_LEAKY = 2, ACT_RELU6 = 3.
  - Q8.8 constants: Q_ONE = 16'h0100, Q_SIX = 16'h0600.
- Sub-module activation_lane: combinational single-lane function, parameterised by WIDTH, FRAC and LEAK_SHIFT; instantiated LANES times by a generate loop.
- Pipeline control and the zero-count logic stay in activation_unit.

Test Plan:
- Reset then idle: out_val = 0, in_rdy = 1, out_data = 0. Check again after reset is asserted with 2 beats in flight: nothing emitted afterwards.
- RELU, LANES = 4, lanes {0x0100, 0xFF00, 0x0000, 0x8000}: exactly 2 cycles later {0x0100, 0x0000, 0x0000, 0x0000}; with the macro, out_zeros = 3.
- LEAKY: {0xFF00, 0x8000, 0x0280, 0xFFFF} gives {0xFFE0, 0xF000, 0x0280, 0xFFFF}. RELU6: {0x0700, 0x0500, 0x7FFF, 0xFA00} gives {0x0600, 0x0500, 0x0600, 0x0000}.
- Backpressure:
  - Hold out_rdy = 0 and offer 3 beats A, B, C: A and B are accepted, in_rdy drops, C waits and out_data holds A.
  - Release out_rdy: the output order is A, B, C.
- Throughput and mode change: 10 back-to-back beats with out_rdy = 1 and the mode cycling 0→1→2→3: one output per cycle, each beat using its own mode.
- Random: 10000 beats, random data, mode and out_rdy, checked against a scoreboard model for value, order and out_zeros.

Source files
------------

// File: rtl/npu_pkg.sv
// Shared NPU datapath types: activation mode encoding and Q8.8 constants.
// No ports; imported by the activation unit, its lanes and its bus interface.
package npu_pkg;

    typedef enum logic [1:0] {
        ACT_PASS  = 2'd0,
        ACT_RELU  = 2'd1,
        ACT_LEAKY = 2'd2,
        ACT_RELU6 = 2'd3
    } act_mode_t;

    localparam logic [15:0] Q_ONE = 16'h0100;
    localparam logic [15:0] Q_SIX = 16'h0600;

endpackage

// File: rtl/activation_unit_if.sv
// Valid/ready bus of the activation unit: input beat side and output beat side.
// Signals: in_val/in_rdy/in_mode/in_data, out_val/out_rdy/out_data and, with
// ACTIVATION_ZCNT_EN defined, out_zeros. master = environment, slave = unit.
interface activation_unit_if import npu_pkg::*; #(
    parameter int WIDTH = 16,
    parameter int LANES = 4
);

    logic                   in_val;
    logic                   in_rdy;
    act_mode_t              in_mode;
    logic [LANES*WIDTH-1:0] in_data;
    logic                   out_val;
    logic                   out_rdy;
    logic [LANES*WIDTH-1:0] out_data;

`ifdef ACTIVATION_ZCNT_EN
    localparam int ZW = $clog2(LANES + 1);
    logic [ZW-1:0]          out_zeros;

    modport master (
        output in_val, in_mode, in_data, out_rdy,
        input  in_rdy, out_val, out_data, out_zeros
    );

    modport slave (
        input  in_val, in_mode, in_data, out_rdy,
        output in_rdy, out_val, out_data, out_zeros
    );
`else
    modport master (
        output in_val, in_mode, in_data, out_rdy,
        input  in_rdy, out_val, out_data
    );

    modport slave (
        input  in_val, in_mode, in_data, out_rdy,
        output in_rdy, out_val, out_data
    );
`endif

endinterface

// File: rtl/activation_lane.sv
// Combinational single-lane activation on a signed fixed-point value.
// Ports: x (lane input), mode (activation select), y (activated lane output).
module activation_lane import npu_pkg::*; #(
    parameter int WIDTH      = 16,
    parameter int FRAC       = 8,
    parameter int LEAK_SHIFT = 3
) (
    input  logic [WIDTH-1:0] x,
    input  act_mode_t        mode,
    output logic [WIDTH-1:0] y
);

    localparam logic signed [WIDTH-1:0] CEIL = WIDTH'(6 << FRAC);

    logic signed [WIDTH-1:0] xs;
    logic                    neg;
    logic        [WIDTH-1:0] leak;

    assign xs   = $signed(x);
    assign neg  = xs[WIDTH-1];
    // arithmetic shift floors toward -inf, so a negative input stays <= 0
    assign leak = xs >>> LEAK_SHIFT;

    always_comb begin
        y = x;
        unique case (1'b1)
            (mode == ACT_PASS):  y = x;
            (mode == ACT_RELU):  y = neg ? '0 : x;
            (mode == ACT_LEAKY): y = neg ? leak : x;
            (mode == ACT_RELU6): y = neg ? '0 : ((xs > CEIL) ? CEIL : x);
            default:             y = x;
        endcase
    end

endmodule

// File: rtl/activation_unit.sv
// Multi-lane 2-stage valid/ready activation pipeline (S1: data+mode, S2: result).
// Ports: clk, rst (sync, active-high), bus (activation_unit_if.slave).
// Optional: ACTIVATION_ZCNT_EN adds a registered per-beat zero-lane count.
module activation_unit import npu_pkg::*; #(
    parameter int WIDTH      = 16,
    parameter int FRAC       = 8,
    parameter int LANES      = 4,
    parameter int LEAK_SHIFT = 3
) (
    input  logic               clk,
    input  logic               rst,
    activation_unit_if.slave   bus
);

    localparam int DW = LANES * WIDTH;

    logic          s1_val;
    logic [DW-1:0] s1_data;
    act_mode_t     s1_mode;
    logic          s2_val;
    logic [DW-1:0] s2_data;
    logic [DW-1:0] act;
    logic          s2_load;
    logic          in_xfer;

    // S2 refills whenever it is empty or draining this cycle
    assign s2_load    = s1_val && (!s2_val || bus.out_rdy);
    assign bus.in_rdy = !s1_val || s2_load;
    assign in_xfer    = bus.in_val && bus.in_rdy;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        activation_lane #(
            .WIDTH      (WIDTH),
            .FRAC       (FRAC),
            .LEAK_SHIFT (LEAK_SHIFT)
        ) u_lane (
            .x    (s1_data[i*WIDTH +: WIDTH]),
            .mode (s1_mode),
            .y    (act[i*WIDTH +: WIDTH])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_val  <= 1'b0;
            s1_data <= '0;
            s1_mode <= ACT_PASS;
            s2_val  <= 1'b0;
            s2_data <= '0;
        end else begin
            if (s2_load) begin
                s2_val  <= 1'b1;
                s2_data <= act;
            end else if (bus.out_rdy) begin
                s2_val  <= 1'b0;
            end
            if (in_xfer) begin
                s1_val  <= 1'b1;
                s1_data <= bus.in_data;
                s1_mode <= bus.in_mode;
            end else if (s2_load) begin
                s1_val  <= 1'b0;
            end
        end
    end

    assign bus.out_val  = s2_val;
    assign bus.out_data = s2_data;

`ifdef ACTIVATION_ZCNT_EN
    localparam int ZW = $clog2(LANES + 1);

    logic [ZW-1:0] zcnt;
    logic [ZW-1:0] s2_zeros;

    always_comb begin
        zcnt = '0;
        for (int i = 0; i < LANES; i++) begin
            if (act[i*WIDTH +: WIDTH] == '0) zcnt = zcnt + ZW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_zeros <= '0;
        end else if (s2_load) begin
            s2_zeros <= zcnt;
        end
    end

    assign bus.out_zeros = s2_zeros;
`endif

endmodule

// File: tb/tb_activation_unit.sv
// Self-checking bench for activation_unit: directed vector table, stall,
// throughput, mid-stream reset and random scoreboard sequences.
module tb_activation_unit;
    import npu_pkg::*;

    localparam int W  = 16;
    localparam int L  = 4;
    localparam int DW = W * L;

    typedef struct {
        logic [DW-1:0] data;
        logic [2:0]    zeros;
    } beat_t;

    typedef struct {
        act_mode_t     mode;
        logic [DW-1:0] din;
        logic [DW-1:0] dout;
        logic [2:0]    zeros;
    } vec_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    activation_unit_if #(.WIDTH(W), .LANES(L)) bus ();

    activation_unit #(
        .WIDTH      (W),
        .FRAC       (8),
        .LANES      (L),
        .LEAK_SHIFT (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int    checks   = 0;
    int    failures = 0;
    int    nout     = 0;
    int    stalls   = 0;
    int    cyc      = 0;
    bit    rand_rdy = 1'b0;
    beat_t exp_q[$];
    int    out_cyc[$];
    vec_t  vecs[7];

    function automatic logic [DW-1:0] pk(logic [15:0] a, logic [15:0] b,
                                         logic [15:0] c, logic [15:0] d);
        return {d, c, b, a};
    endfunction

    function automatic logic [15:0] lane_model(logic [15:0] x, logic [1:0] m);
        int v;
        int r;
        v = int'($signed(x));
        case (m)
            2'd1:    r = (v < 0) ? 0 : v;
            2'd2:    r = (v < 0) ? -((-v + 7) / 8) : v;
            2'd3:    r = (v < 0) ? 0 : ((v > 1536) ? 1536 : v);
            default: r = v;
        endcase
        return r[15:0];
    endfunction

    function automatic beat_t beat_model(logic [DW-1:0] d, logic [1:0] m);
        beat_t b;
        logic [15:0] y;
        b.data  = '0;
        b.zeros = '0;
        for (int i = 0; i < L; i++) begin
            y = lane_model(d[i*W +: W], m);
            b.data[i*W +: W] = y;
            if (y == 16'h0000) b.zeros = b.zeros + 3'd1;
        end
        return b;
    endfunction

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // negedge: scoreboard bookkeeping on both handshakes
    task automatic sample();
        beat_t e;
        @(negedge clk);
        if (rst) begin
            exp_q.delete();
        end else begin
            if (bus.in_val && bus.in_rdy)
                exp_q.push_back(beat_model(bus.in_data, bus.in_mode));
            if (bus.out_val && bus.out_rdy) begin
                nout++;
                out_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_extra got=%h exp=none", bus.out_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_data", bus.out_data, e.data);
`ifdef ACTIVATION_ZCNT_EN
                    chk("sb_zeros", 64'(bus.out_zeros), 64'(e.zeros));
`endif
                end
            end
        end
        cyc++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) bus.out_rdy = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [DW-1:0] d, input act_mode_t m);
        bit acc;
        acc = 1'b0;
        bus.in_val  = 1'b1;
        bus.in_data = d;
        bus.in_mode = m;
        for (int k = 0; k < 200; k++) begin
            sample();
            acc = bus.in_rdy;
            if (!acc) stalls++;
            tick();
            if (acc) break;
        end
        if (!acc) chk("send_timeout", 64'(acc), 64'd1);
        bus.in_val = 1'b0;
    endtask

    task automatic drain();
        rand_rdy    = 1'b0;
        bus.out_rdy = 1'b1;
        for (int k = 0; k < 100; k++) begin
            if (exp_q.size() == 0) break;
            sample();
            tick();
        end
        chk("drain_left", 64'(exp_q.size()), 64'd0);
    endtask

    function automatic logic [15:0] rand_lane();
        case ($urandom_range(0, 7))
            0:       return 16'h8000;
            1:       return 16'h7FFF;
            2:       return 16'h0000;
            3:       return 16'h0600;
            4:       return 16'h0601;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        vecs[0] = '{ACT_RELU,  pk(16'h0100, 16'hFF00, 16'h0000, 16'h8000),
                               pk(16'h0100, 16'h0000, 16'h0000, 16'h0000), 3'd3};
        vecs[1] = '{ACT_LEAKY, pk(16'hFF00, 16'h8000, 16'h0280, 16'hFFFF),
                               pk(16'hFFE0, 16'hF000, 16'h0280, 16'hFFFF), 3'd0};
        vecs[2] = '{ACT_RELU6, pk(16'h0700, 16'h0500, 16'h7FFF, 16'hFA00),
                               pk(16'h0600, 16'h0500, 16'h0600, 16'h0000), 3'd1};
        vecs[3] = '{ACT_PASS,  pk(16'h8000, 16'h7FFF, 16'h0000, 16'h1234),
                               pk(16'h8000, 16'h7FFF, 16'h0000, 16'h1234), 3'd1};
        vecs[4] = '{ACT_RELU6, pk(16'h0600, 16'h0601, 16'h8000, 16'h0000),
                               pk(16'h0600, 16'h0600, 16'h0000, 16'h0000), 3'd2};
        vecs[5] = '{ACT_LEAKY, pk(16'h0007, 16'h0000, 16'hFFF8, 16'hFFF9),
                               pk(16'h0007, 16'h0000, 16'hFFFF, 16'hFFFF), 3'd1};
        vecs[6] = '{ACT_RELU,  pk(16'h7FFF, 16'h0001, 16'hFFFF, 16'h0000),
                               pk(16'h7FFF, 16'h0001, 16'h0000, 16'h0000), 3'd2};

        rst         = 1'b1;
        bus.in_val  = 1'b0;
        bus.in_mode = ACT_PASS;
        bus.in_data = '0;
        bus.out_rdy = 1'b1;
        repeat (3) begin
            sample();
            tick();
        end
        rst = 1'b0;
        sample();
        chk("rst_out_val", 64'(bus.out_val), 64'd0);
        chk("rst_in_rdy", 64'(bus.in_rdy), 64'd1);
        chk("rst_out_data", bus.out_data, 64'd0);
`ifdef ACTIVATION_ZCNT_EN
        chk("rst_zeros", 64'(bus.out_zeros), 64'd0);
`endif
        tick();

        // directed vectors, single beat each, 2-cycle latency
        foreach (vecs[i]) begin
            send(vecs[i].din, vecs[i].mode);
            sample();
            chk("lat1_val", 64'(bus.out_val), 64'd0);
            tick();
            sample();
            chk("vec_val", 64'(bus.out_val), 64'd1);
            chk("vec_data", bus.out_data, vecs[i].dout);
`ifdef ACTIVATION_ZCNT_EN
            chk("vec_zeros", 64'(bus.out_zeros), 64'(vecs[i].zeros));
`endif
            tick();
        end

        // backpressure: A and B buffered, C blocked, A held at the output
        bus.out_rdy = 1'b0;
        send(pk(16'h0001, 16'h0002, 16'h0003, 16'h0004), ACT_PASS);
        send(pk(16'hFFFF, 16'h0005, 16'h0006, 16'h0007), ACT_RELU);
        bus.in_val  = 1'b1;
        bus.in_data = pk(16'h8000, 16'h0008, 16'h0009, 16'h000A);
        bus.in_mode = ACT_LEAKY;
        repeat (3) begin
            sample();
            chk("bp_in_rdy", 64'(bus.in_rdy), 64'd0);
            chk("bp_out_val", 64'(bus.out_val), 64'd1);
            chk("bp_hold_a", bus.out_data,
                pk(16'h0001, 16'h0002, 16'h0003, 16'h0004));
            tick();
        end
        bus.out_rdy = 1'b1;
        begin
            bit acc;
            acc = 1'b0;
            for (int k = 0; k < 20; k++) begin
                sample();
                acc = bus.in_rdy;
                tick();
                if (acc) break;
            end
            chk("bp_c_accept", 64'(acc), 64'd1);
        end
        bus.in_val = 1'b0;
        drain();

        // throughput with mode cycling
        out_cyc.delete();
        stalls = 0;
        begin
            int n0;
            n0 = nout;
            for (int i = 0; i < 10; i++)
                send(pk(rand_lane(), rand_lane(), rand_lane(), rand_lane()),
                     act_mode_t'(i % 4));
            drain();
            chk("tp_stalls", 64'(stalls), 64'd0);
            chk("tp_count", 64'(nout - n0), 64'd10);
            if (out_cyc.size() == 10)
                chk("tp_span", 64'(out_cyc[9] - out_cyc[0]), 64'd9);
        end

        // reset with two beats in flight
        bus.out_rdy = 1'b0;
        send(pk(16'h1111, 16'h2222, 16'h3333, 16'h4444), ACT_PASS);
        send(pk(16'h5555, 16'h6666, 16'h7777, 16'h0000), ACT_PASS);
        rst = 1'b1;
        sample();
        tick();
        rst = 1'b0;
        sample();
        chk("mrst_out_val", 64'(bus.out_val), 64'd0);
        chk("mrst_in_rdy", 64'(bus.in_rdy), 64'd1);
        chk("mrst_out_data", bus.out_data, 64'd0);
        tick();
        bus.out_rdy = 1'b1;
        repeat (4) begin
            sample();
            chk("mrst_no_out", 64'(bus.out_val), 64'd0);
            tick();
        end

        // random beats with random backpressure
        rand_rdy = 1'b1;
        for (int n = 0; n < 10000; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                sample();
                tick();
            end
            send(pk(rand_lane(), rand_lane(), rand_lane(), rand_lane()),
                 act_mode_t'($urandom_range(0, 3)));
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
